// File: rtl/cpu_pio_edge.sv
// Avalon-MM GPIO slave: per-bit direction, input synchroniser, edge capture with masked level irq.
// Optional OUTSET/OUTCLR registers at addresses 4/5 when CPU_PIO_BITSET_EN is defined.
// Inputs pulses shorter than one clk period may be missed by the synchroniser.
module cpu_pio_edge #(
    parameter int unsigned     WIDTH       = 12,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_DIR  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  out_oe,
    output logic              irq
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef CPU_PIO_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] irqmask_q;

    logic             wr;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] irqmask_next;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] dir_next;
    logic [WIDTH-1:0] rd_mux;
    logic             unused_wdata_bits;

    assign unused_wdata_bits = ^writedata;

    // Register update and read mux; a new edge overrides a same-cycle W1C.
    always_comb begin
        wr           = chipselect & ~write_n;
        wdata_w      = writedata[WIDTH-1:0];
        sync_last    = sync_q[SYNC_STAGES-1];
        edge_hit     = '0;
        edgecap_next = edgecap_q;
        irqmask_next = irqmask_q;
        data_next    = out_port;
        dir_next     = out_oe;
        rd_mux       = '0;

        case (EDGE_TYPE)
            32'd0:   edge_hit = sync_last & ~prev_q;
            32'd1:   edge_hit = ~sync_last & prev_q;
            default: edge_hit = sync_last ^ prev_q;
        endcase

        if (wr) begin
            case (address)
                ADDR_DATA:    data_next    = wdata_w;
                ADDR_DIR:     dir_next     = wdata_w;
                ADDR_IRQMASK: irqmask_next = wdata_w;
                ADDR_EDGECAP: edgecap_next = edgecap_q & ~wdata_w;
`ifdef CPU_PIO_BITSET_EN
                ADDR_OUTSET:  data_next    = out_port | wdata_w;
                ADDR_OUTCLR:  data_next    = out_port & ~wdata_w;
`endif
                default:      ;
            endcase
        end
        edgecap_next = edgecap_next | edge_hit;

        case (address)
            ADDR_DATA:    rd_mux = (out_port & out_oe) | (sync_last & ~out_oe);
            ADDR_DIR:     rd_mux = out_oe;
            ADDR_IRQMASK: rd_mux = irqmask_q;
            ADDR_EDGECAP: rd_mux = edgecap_q;
            default:      rd_mux = '0;
        endcase
    end

    // All state, including the synchroniser, clears asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
            out_port  <= '0;
            out_oe    <= RESET_DIR;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q    <= sync_last;
            edgecap_q <= edgecap_next;
            irqmask_q <= irqmask_next;
            out_port  <= data_next;
            out_oe    <= dir_next;
            readdata  <= DW'(rd_mux);
            irq       <= |(edgecap_next & irqmask_next);
        end
    end

endmodule

// File: tb/tb_cpu_pio_edge.sv
// Directed self-checking bench for cpu_pio_edge: a 12-bit instance and a 32-bit instance.
module tb_cpu_pio_edge;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs12;
    logic        cs32;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata12;
    logic [31:0] readdata32;
    logic [11:0] in_port12;
    logic [11:0] out_port12;
    logic [11:0] out_oe12;
    logic        irq12;
    logic [31:0] in_port32;
    logic [31:0] out_port32;
    logic [31:0] out_oe32;
    logic        irq32;

    int total;
    int passed;

    cpu_pio_edge #(
        .WIDTH(12), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_DIR(12'h0F0)
    ) dut12 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs12),
        .write_n(write_n), .writedata(writedata), .readdata(readdata12),
        .in_port(in_port12), .out_port(out_port12), .out_oe(out_oe12), .irq(irq12)
    );

    cpu_pio_edge #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_DIR(32'h0)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .readdata(readdata32),
        .in_port(in_port32), .out_port(out_port32), .out_oe(out_oe32), .irq(irq32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input bit sel32, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write_n = 1'b0;
        cs12 = ~sel32; cs32 = sel32;
        @(negedge clk);
        write_n = 1'b1; cs12 = 1'b0; cs32 = 1'b0;
    endtask

    task automatic bus_read(input bit sel32, input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = sel32 ? readdata32 : readdata12;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        total++;
        if (out_oe12 !== 12'h0F0 || out_port12 !== 12'h000 || readdata12 !== 32'h0 || irq12 !== 1'b0)
            $display("FAIL reset_initial: oe=%h out=%h rd=%h irq=%b want oe=0f0 out=000 rd=0 irq=0",
                     out_oe12, out_port12, readdata12, irq12);
        else passed++;
        @(negedge clk); reset_n = 1'b1;
        bus_write(1'b0, 3'd1, 32'h0FF);
        bus_write(1'b0, 3'd0, 32'hABC);
        bus_read(1'b0, 3'd1, rd);
        total++;
        if (rd !== 32'h0FF) $display("FAIL dir_readback: got %h want 000000ff", rd);
        else passed++;
        @(negedge clk);
        address = 3'd0; writedata = 32'hFFF; write_n = 1'b0; cs12 = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_port12 !== 12'h000 || out_oe12 !== 12'h0F0 || readdata12 !== 32'h0 || irq12 !== 1'b0)
            $display("FAIL reset_midwrite: out=%h oe=%h rd=%h irq=%b want out=000 oe=0f0 rd=0 irq=0",
                     out_port12, out_oe12, readdata12, irq12);
        else passed++;
        @(negedge clk);
        write_n = 1'b1; cs12 = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        total++;
        if (out_port12 !== 12'h000 || out_oe32 !== 32'h0)
            $display("FAIL reset_hold: out12=%h oe32=%h want 000 and 0", out_port12, out_oe32);
        else passed++;
    endtask

    task automatic test_dir_data;
        logic [31:0] rd;
        in_port12 = 12'h555;
        bus_write(1'b0, 3'd1, 32'h00F);
        bus_write(1'b0, 3'd0, 32'hABC);
        idle(2);
        bus_read(1'b0, 3'd0, rd);
        total++;
        if (rd !== 32'h55C) $display("FAIL data_read_mixed: got %h want 0000055c", rd);
        else passed++;
        total++;
        if (out_port12 !== 12'hABC || out_oe12 !== 12'h00F)
            $display("FAIL out_port_oe: out=%h oe=%h want abc 00f", out_port12, out_oe12);
        else passed++;
    endtask

    task automatic test_edge_irq;
        logic [31:0] rd;
        in_port12 = 12'h000;
        idle(4);
        bus_write(1'b0, 3'd3, 32'hFFF);
        bus_write(1'b0, 3'd2, 32'h001);
        bus_read(1'b0, 3'd3, rd);
        total++;
        if (rd !== 32'h0 || irq12 !== 1'b0)
            $display("FAIL edgecap_cleared: cap=%h irq=%b want 0 0", rd, irq12);
        else passed++;
        @(negedge clk); in_port12 = 12'h001;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (irq12 !== 1'b0) $display("FAIL irq_early: got %b want 0 after edge N+1", irq12);
        else passed++;
        @(negedge clk);
        total++;
        if (irq12 !== 1'b1) $display("FAIL irq_rise: got %b want 1 after edge N+2", irq12);
        else passed++;
        bus_read(1'b0, 3'd3, rd);
        total++;
        if (rd !== 32'h001) $display("FAIL edgecap_bit0: got %h want 00000001", rd);
        else passed++;
        in_port12 = 12'h003;
        idle(4);
        bus_read(1'b0, 3'd3, rd);
        total++;
        if (rd !== 32'h003 || irq12 !== 1'b1)
            $display("FAIL edgecap_bit1: cap=%h irq=%b want 003 1", rd, irq12);
        else passed++;
    endtask

    task automatic test_w1c_race;
        logic [31:0] rd;
        in_port12 = 12'h002;
        idle(4);
        @(negedge clk); in_port12 = 12'h003;
        @(negedge clk);
        @(negedge clk);
        address = 3'd3; writedata = 32'h001; write_n = 1'b0; cs12 = 1'b1;
        @(negedge clk);
        write_n = 1'b1; cs12 = 1'b0;
        total++;
        if (irq12 !== 1'b1) $display("FAIL race_irq: got %b want 1", irq12);
        else passed++;
        bus_read(1'b0, 3'd3, rd);
        total++;
        if (rd !== 32'h003) $display("FAIL race_edgecap: got %h want 00000003", rd);
        else passed++;
        bus_write(1'b0, 3'd3, 32'h001);
        total++;
        if (irq12 !== 1'b0) $display("FAIL w1c_irq_drop: got %b want 0", irq12);
        else passed++;
        bus_read(1'b0, 3'd3, rd);
        total++;
        if (rd !== 32'h002) $display("FAIL w1c_edgecap: got %h want 00000002", rd);
        else passed++;
    endtask

    task automatic test_bitset;
        logic [31:0] rd;
        logic [11:0] exp_set;
        logic [11:0] exp_clr;
`ifdef CPU_PIO_BITSET_EN
        exp_set = 12'h0FF;
        exp_clr = 12'h00F;
`else
        exp_set = 12'h0F0;
        exp_clr = 12'h0F0;
`endif
        bus_write(1'b0, 3'd0, 32'h0F0);
        bus_write(1'b0, 3'd4, 32'h00F);
        total++;
        if (out_port12 !== exp_set) $display("FAIL outset: got %h want %h", out_port12, exp_set);
        else passed++;
        bus_read(1'b0, 3'd4, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL outset_read: got %h want 0", rd);
        else passed++;
        bus_write(1'b0, 3'd5, 32'h0F0);
        total++;
        if (out_port12 !== exp_clr) $display("FAIL outclr: got %h want %h", out_port12, exp_clr);
        else passed++;
        bus_read(1'b0, 3'd5, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL outclr_read: got %h want 0", rd);
        else passed++;
        bus_write(1'b0, 3'd6, 32'hFFF);
        bus_read(1'b0, 3'd6, rd);
        total++;
        if (rd !== 32'h0 || out_port12 !== exp_clr)
            $display("FAIL addr6: rd=%h out=%h want 0 %h", rd, out_port12, exp_clr);
        else passed++;
    endtask

    task automatic test_width32;
        logic [31:0] rd;
        bus_write(1'b1, 3'd1, 32'hFFFF_FFFF);
        bus_write(1'b1, 3'd0, 32'hFFFF_FFFF);
        bus_read(1'b1, 3'd0, rd);
        total++;
        if (rd !== 32'hFFFF_FFFF || out_port32 !== 32'hFFFF_FFFF)
            $display("FAIL width32_data: rd=%h out=%h want ffffffff", rd, out_port32);
        else passed++;
        bus_read(1'b1, 3'd7, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL width32_addr7: got %h want 0", rd);
        else passed++;
        total++;
        if (out_port12 === 12'hFFF) $display("FAIL width32_isolation: dut12 out=%h changed", out_port12);
        else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        reset_n = 1'b0; address = 3'd0; cs12 = 1'b0; cs32 = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port12 = 12'h0; in_port32 = 32'h0;
        idle(2);
        test_reset();
        test_dir_data();
        test_edge_irq();
        test_w1c_race();
        test_bitset();
        test_width32();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
